// File: rtl/sequential_subtractor_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state
// encoding and the helper that derives how many blocks an operand holds.
package sequential_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

  function automatic int stages_count(input int data_width, input int block_size);
    return data_width / block_size;
  endfunction

endpackage

// File: rtl/sequential_subtractor_adder.sv
// Block-wide adder used by the sequential arithmetic blocks. The overflow
// output compares the carry into the MSB with the carry out of the MSB.
module ripple_carry_adder #(
  parameter int DATA_WIDTH     = 4,
  parameter int OVERFLOW_LOGIC = 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  overflow
);

  // Whole-block sum with its carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};

  generate
    if (OVERFLOW_LOGIC != 0) begin : g_ovf
      logic carry_into_msb;
      // The carry into the MSB is recovered from the MSB sum bit.
      assign carry_into_msb = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1] ^ sum[DATA_WIDTH-1];
      assign overflow       = carry_into_msb ^ cout;
    end else begin : g_no_ovf
      assign overflow = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sequential_subtractor.sv
// Multi-cycle subtractor: computes A - B as A + ~B + 1, one BLOCK_SIZE
// slice per clock, and publishes S, CF and OF when the last slice is done.
module sequential_subtractor
  import sequential_subtractor_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF
);

  localparam int STAGES_COUNT = stages_count(DATA_WIDTH, BLOCK_SIZE);
  localparam int CNT_W        = (STAGES_COUNT > 1) ? $clog2(STAGES_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(STAGES_COUNT - 1);

  sub_state_t state, next_state;

  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] nb_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic [DATA_WIDTH-1:0] result_next;
  logic                  carry_reg;
  logic [CNT_W-1:0]      blk_cnt;
  logic                  accept;
  logic                  last_blk;

  logic [BLOCK_SIZE-1:0] blk_a;
  logic [BLOCK_SIZE-1:0] blk_b;
  logic [BLOCK_SIZE-1:0] blk_sum;
  logic                  blk_cout;
  logic                  blk_ovf;

  assign blk_a = a_reg[blk_cnt*BLOCK_SIZE +: BLOCK_SIZE];
  assign blk_b = nb_reg[blk_cnt*BLOCK_SIZE +: BLOCK_SIZE];

  ripple_carry_adder #(
    .DATA_WIDTH    (BLOCK_SIZE),
    .OVERFLOW_LOGIC(1)
  ) u_block_adder (
    .a       (blk_a),
    .b       (blk_b),
    .cin     (carry_reg),
    .sum     (blk_sum),
    .cout    (blk_cout),
    .overflow(blk_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus the busy/done flags and start acceptance.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_blk   = (blk_cnt == LAST_BLK);
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_blk) next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Partial result with the current block's sum merged into its slot.
  always_comb begin
    result_next = result_reg;
    result_next[blk_cnt*BLOCK_SIZE +: BLOCK_SIZE] = blk_sum;
  end

  // Operand capture, per-block accumulation and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      nb_reg     <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      blk_cnt    <= '0;
      S          <= '0;
      CF         <= 1'b0;
      OF         <= 1'b0;
    end else if (accept) begin
      a_reg     <= A;
      nb_reg    <= ~B;
      carry_reg <= 1'b1;
      blk_cnt   <= '0;
    end else if (busy) begin
      result_reg <= result_next;
      carry_reg  <= blk_cout;
      blk_cnt    <= blk_cnt + 1'b1;
      if (last_blk) begin
        S  <= result_next;
        CF <= ~blk_cout;
        OF <= blk_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sequential_subtractor.sv
// Self-checking bench for sequential_subtractor: an arithmetic reference
// model checked every cycle, plus directed operations with literal results.
module tb_sequential_subtractor;

  localparam int DW     = 16;
  localparam int BS     = 4;
  localparam int STAGES = DW / BS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          busy;
  logic          done;
  logic [DW-1:0] S;
  logic          CF;
  logic          OF;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sequential_subtractor #(
    .DATA_WIDTH(DW),
    .BLOCK_SIZE(BS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .S    (S),
    .CF   (CF),
    .OF   (OF)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is in flight for STAGES edges after its
  // accepting edge; results are plain two's-complement arithmetic.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_s    = '0;
  logic          m_cf   = 1'b0;
  logic          m_of   = 1'b0;
  logic [DW-1:0] p_s;
  logic          p_cf;
  logic          p_of;
  int            m_left = 0;

  always @(posedge clk) begin
    int sd;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_s    = '0;
      m_cf   = 1'b0;
      m_of   = 1'b0;
      m_left = 0;
    end else if (!m_busy && start) begin
      sd     = int'($signed(A)) - int'($signed(B));
      p_s    = A - B;
      p_cf   = (A < B);
      p_of   = (sd > 32767) || (sd < -32768);
      m_busy = 1'b1;
      m_done = 1'b0;
      m_left = STAGES;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_s    = p_s;
        m_cf   = p_cf;
        m_of   = p_of;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("busy", 32'(busy), 32'(m_busy));
      check1("done", 32'(done), 32'(m_done));
      check1("S",    32'(S),    32'(m_s));
      check1("CF",   32'(CF),   32'(m_cf));
      check1("OF",   32'(OF),   32'(m_of));
    end
  end

  // Issues one operation from a non-busy cycle and waits (bounded) for done.
  task automatic applyStimulus(input logic [DW-1:0] a_in, input logic [DW-1:0] b_in,
                               output int latency);
    A     = a_in;
    B     = b_in;
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    A       = $urandom_range(0, 16'hFFFF);
    B       = $urandom_range(0, 16'hFFFF);
    latency = 0;
    while (!done && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
    if (!done) check1("done_timeout", 32'(done), 32'd1);
  endtask

  // Literal result check, including the measured latency.
  task automatic checkOutput(input string name, input int latency,
                             input logic [DW-1:0] exp_s, input logic exp_cf,
                             input logic exp_of);
    $display("[TB] %s: S=0x%04h CF=%0b OF=%0b latency=%0d", name, S, CF, OF, latency);
    check1({name, "_latency"}, 32'(latency), 32'(STAGES));
    check1({name, "_S"},  32'(S),  32'(exp_s));
    check1({name, "_CF"}, 32'(CF), 32'(exp_cf));
    check1({name, "_OF"}, 32'(OF), 32'(exp_of));
  endtask

  initial begin
    int lat;
    int extra;
    bit saw_done;
    rst   = 1'b1;
    start = 1'b0;
    A     = 16'hAAAA;
    B     = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check1("reset_busy", 32'(busy), 32'd0);
    check1("reset_done", 32'(done), 32'd0);
    check1("reset_S",    32'(S),    32'd0);
    check1("reset_CF",   32'(CF),   32'd0);
    check1("reset_OF",   32'(OF),   32'd0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(16'h1234, 16'h0234, lat);
    checkOutput("basic", lat, 16'h1000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check1("idle_after_done", 32'(done), 32'd0);
    check1("hold_S_in_idle",  32'(S),    32'h1000);

    applyStimulus(16'h0000, 16'h0001, lat);
    checkOutput("borrow", lat, 16'hFFFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(16'h8000, 16'h0001, lat);
    checkOutput("neg_ovf", lat, 16'h7FFF, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(16'h7FFF, 16'hFFFF, lat);
    checkOutput("pos_ovf", lat, 16'h8000, 1'b1, 1'b1);

    // Back-to-back: start issued in the done cycle.
    applyStimulus(16'h0005, 16'h0003, lat);
    checkOutput("back2back", lat, 16'h0002, 1'b0, 1'b0);

    // Start pulsed mid-run with other operands must be ignored.
    @(posedge clk);
    #1;
    A     = 16'h0009;
    B     = 16'h0004;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    A     = 16'hFFFF;
    B     = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check1("busy_mid_run", 32'(busy), 32'd1);
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ignore_start", lat, 16'h0005, 1'b0, 1'b0);

    // Reset on the second RUN cycle aborts the operation silently.
    @(posedge clk);
    #1;
    A     = 16'h1111;
    B     = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check1("abort_busy", 32'(busy), 32'd0);
    check1("abort_S",    32'(S),    32'd0);
    check1("abort_CF",   32'(CF),   32'd0);
    check1("abort_OF",   32'(OF),   32'd0);
    saw_done = 1'b0;
    for (extra = 0; extra < 8; extra++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check1("abort_no_done", 32'(saw_done), 32'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sequential_subtractor.md
SEQUENTIAL_SUBTRACTOR -- requirements
Module: sequential_subtractor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4: bits processed per clock; DATA_WIDTH SHALL be a multiple of BLOCK_SIZE, with STAGES_COUNT = DATA_WIDTH / BLOCK_SIZE >= 2.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin A - B; sampled only when busy = 0.
REQ-006 SHALL have port A  input  DATA_WIDTH  minuend; captured on an accepted start.
REQ-007 SHALL have port B  input  DATA_WIDTH  subtrahend; captured on an accepted start.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; S, CF and OF are valid from this cycle on.
REQ-010 SHALL have port S  output  DATA_WIDTH  difference A - B, modulo 2^DATA_WIDTH.
REQ-011 SHALL have port CF  output  1  borrow: 1 iff A < B unsigned.
REQ-012 SHALL have port OF  output  1  signed overflow of A - B in two's complement.

Function
REQ-013 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE with start = 1, SHALL capture A and ~B, set carry register to 1, clear the block counter to 0, and go to RUN.
REQ-015 In RUN, each cycle SHALL add block k of A and ~B plus the carry register, BLOCK_SIZE bits wide, store the sum in bits [(k+1)*BLOCK_SIZE-1 : k*BLOCK_SIZE] of an internal result register, store the block carry-out in the carry register, and increment k.
REQ-016 When k = STAGES_COUNT-1 is processed, SHALL go to DONE and load S, CF and OF at the same clock edge.
REQ-017 CF SHALL equal the inverted final carry-out; OF SHALL equal carry-into-MSB XOR carry-out-of-MSB of the last block.
REQ-018 Latency: if start is accepted at edge t, done SHALL be high in the cycle after edge t+STAGES_COUNT (4 cycles for the defaults); done SHALL be high only in DONE.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 DONE without start SHALL return to IDLE after one cycle; DONE with start SHALL go straight to RUN (back-to-back, no idle cycle).
REQ-021 start while busy = 1 SHALL be ignored; operands and progress SHALL be unaffected.
REQ-022 S, CF and OF SHALL change only at the DONE-entry edge or on reset; they hold their values through IDLE and any later RUN until the next DONE.
REQ-023 A and B SHALL be ignored except on the edge where start is accepted.

Reset
REQ-024 With rst = 1 at a rising edge: state SHALL become IDLE, and busy, done, S, CF, OF, the block counter, the carry register and the operand registers SHALL all become 0.
REQ-025 rst SHALL take priority over start and over any in-progress RUN; an aborted operation SHALL produce no done pulse.

Structure
REQ-026 FSM state encodings and the STAGES_COUNT derivation SHALL live in a shared include header used by the codebase's sequential arithmetic blocks.
REQ-027 The per-block add SHALL be one instance of the existing ripple_carry_adder with DATA_WIDTH = BLOCK_SIZE and OVERFLOW_LOGIC = 1; its operands come from counter-indexed slices of the operand registers.

Verification (DATA_WIDTH = 16, BLOCK_SIZE = 4)
REQ-028 A=0x1234, B=0x0234 -> done 4 cycles after start, S=0x1000, CF=0, OF=0.
REQ-029 A=0x0000, B=0x0001 -> S=0xFFFF, CF=1, OF=0; then A=0x8000, B=0x0001 -> S=0x7FFF, CF=0, OF=1.
REQ-030 A=0x7FFF, B=0xFFFF -> S=0x8000, CF=1, OF=1.
REQ-031 Start asserted in the done cycle with A=0x0005, B=0x0003 -> no IDLE gap, next done 4 cycles later, S=0x0002; start pulsed during RUN -> ignored, result unchanged.
REQ-032 rst asserted on the 2nd RUN cycle -> next cycle busy=0 and S, CF, OF all 0; no done pulse follows.
